// File: rtl/sdram_frame_udp_reader_pkg.sv
// Shared types and constants for the
// SDRAM frame to UDP read path.
package sdram_frame_udp_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    PKT_SETUP,
    RD_REQ,
    RD_DATA,
    TX_WAIT,
    TX_DATA,
    PKT_DONE
  } rd_state_e;

  localparam int BYTES_PER_WORD  = 4;
  localparam int UDP_MAX_PAYLOAD = 1472;

  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  lane
  );
    return w[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sdram_frame_udp_reader_pkt_word_buf.sv
// Packet word buffer: simple dual-port RAM,
// one write port, one registered read port.
module sdram_frame_udp_reader_pkt_word_buf
  import sdram_frame_udp_reader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_frame_udp_reader.sv
// Reads one frame from SDRAM a packet at a time
// and streams each packet as bytes into UDP tx.
module sdram_frame_udp_reader
  import sdram_frame_udp_reader_pkg::*;
#(
  parameter int ADDR_BITS     = 21,
  parameter int MEM_DATA_BITS = 32,
  parameter int RD_BURST      = 64,
  parameter int FRAME_WORDS   = 307200,
  parameter int PKT_WORDS     = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_BITS-1:0]     base_addr,
  output logic                     busy,
  output logic                     frame_done,
  input  logic                     Sdr_init_done,
  input  logic                     Sdr_busy,
  output logic                     App_rd_en,
  output logic [ADDR_BITS-1:0]     App_rd_addr,
  input  logic                     Sdr_rd_en,
  input  logic [MEM_DATA_BITS-1:0] Sdr_rd_dout,
  input  logic                     app_tx_data_request,
  output logic                     app_tx_data_valid,
  output logic [7:0]               app_tx_data,
  output logic [15:0]              udp_data_length,
  input  logic                     udp_tx_ready,
  input  logic                     app_tx_ack
);

  localparam int WLW = $clog2(FRAME_WORDS + 1);
  localparam int PWW = $clog2(PKT_WORDS + 1);
  localparam int LW  = $clog2(BYTES_PER_WORD);
  localparam int BCW = PWW + LW;
  localparam int AW  = $clog2(PKT_WORDS);
  localparam int BW  = $clog2(RD_BURST + 1);

  rd_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [WLW-1:0]       words_left_q, words_left_d;
  logic [PWW-1:0]       pkt_words_q, pkt_words_d;
  logic [PWW-1:0]       wr_idx_q, wr_idx_d;
  logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]          len_q, len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 valid_q, valid_d;
  logic [LW-1:0]        lane_q, lane_d;

  logic                     buf_we;
  logic [MEM_DATA_BITS-1:0] buf_rdata;
  logic [BCW-1:0]           pkt_bytes;

  assign pkt_bytes = {pkt_words_q, {LW{1'b0}}};

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    words_left_d = words_left_q;
    pkt_words_d  = pkt_words_q;
    wr_idx_d     = wr_idx_q;
    burst_cnt_d  = burst_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    valid_d      = 1'b0;
    lane_d       = lane_q;
    buf_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d     = base_addr;
          words_left_d = WLW'(FRAME_WORDS);
          busy_d       = 1'b1;
          state_d      = WAIT_INIT;
        end
      end
      WAIT_INIT: begin
        if (Sdr_init_done) begin
          state_d = PKT_SETUP;
        end
      end
      PKT_SETUP: begin
        if (32'(words_left_q) < 32'(PKT_WORDS)) begin
          pkt_words_d = PWW'(words_left_q);
        end else begin
          pkt_words_d = PWW'(PKT_WORDS);
        end
        wr_idx_d    = '0;
        burst_cnt_d = '0;
        state_d     = RD_REQ;
      end
      RD_REQ: begin
        if (!Sdr_busy) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_ptr_q;
          rd_ptr_d  = rd_ptr_q + ADDR_BITS'(RD_BURST);
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (Sdr_rd_en) begin
          buf_we   = 1'b1;
          wr_idx_d = wr_idx_q + PWW'(1);
          if (burst_cnt_q == BW'(RD_BURST - 1)) begin
            burst_cnt_d = '0;
            if (wr_idx_d < pkt_words_q) begin
              state_d = RD_REQ;
            end else begin
              len_d   = 16'(pkt_bytes);
              state_d = TX_WAIT;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end
      end
      TX_WAIT: begin
        if (udp_tx_ready) begin
          byte_cnt_d = '0;
          state_d    = TX_DATA;
        end
      end
      TX_DATA: begin
        // byte_cnt only moves on accepted requests, so gaps resume cleanly
        if (app_tx_data_request && byte_cnt_q < pkt_bytes) begin
          valid_d    = 1'b1;
          lane_d     = byte_cnt_q[LW-1:0];
          byte_cnt_d = byte_cnt_q + BCW'(1);
        end
        if (app_tx_ack && byte_cnt_q == pkt_bytes) begin
          state_d = PKT_DONE;
        end
      end
      PKT_DONE: begin
        words_left_d = words_left_q - WLW'(pkt_words_q);
        len_d        = '0;
        if (words_left_d == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = PKT_SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      words_left_q <= '0;
      pkt_words_q  <= '0;
      wr_idx_q     <= '0;
      burst_cnt_q  <= '0;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      valid_q      <= 1'b0;
      lane_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      words_left_q <= words_left_d;
      pkt_words_q  <= pkt_words_d;
      wr_idx_q     <= wr_idx_d;
      burst_cnt_q  <= burst_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      len_q        <= len_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      valid_q      <= valid_d;
      lane_q       <= lane_d;
    end
  end

  sdram_frame_udp_reader_pkt_word_buf #(
    .DEPTH (PKT_WORDS),
    .DW    (MEM_DATA_BITS),
    .AW    (AW)
  ) u_pkt_word_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx_q[AW-1:0]),
    .wdata (Sdr_rd_dout),
    .raddr (byte_cnt_q[LW +: AW]),
    .rdata (buf_rdata)
  );

  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign App_rd_en         = rd_en_q;
  assign App_rd_addr       = rd_addr_q;
  assign app_tx_data_valid = valid_q;
  assign udp_data_length   = len_q;
  // masked so the byte bus reads 0 whenever no byte is offered
  assign app_tx_data = valid_q ? word_byte(buf_rdata, lane_q) : 8'h00;

endmodule

// File: tb/tb_sdram_frame_udp_reader.sv
// Scoreboard bench: SDRAM read model, UDP sink
// model, expected bursts/bytes queued per frame.
module tb_sdram_frame_udp_reader;

  localparam int AB = 21;
  localparam int RB = 64;
  localparam int FW = 320;
  localparam int PW = 256;
  localparam int TMO = 8000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [AB-1:0] base_addr;
  logic          busy;
  logic          frame_done;
  logic          Sdr_init_done;
  logic          Sdr_busy;
  logic          App_rd_en;
  logic [AB-1:0] App_rd_addr;
  logic          Sdr_rd_en;
  logic [31:0]   Sdr_rd_dout;
  logic          app_tx_data_request;
  logic          app_tx_data_valid;
  logic [7:0]    app_tx_data;
  logic [15:0]   udp_data_length;
  logic          udp_tx_ready;
  logic          app_tx_ack;

  always #5 clk = ~clk;

  sdram_frame_udp_reader #(
    .ADDR_BITS     (AB),
    .MEM_DATA_BITS (32),
    .RD_BURST      (RB),
    .FRAME_WORDS   (FW),
    .PKT_WORDS     (PW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .base_addr           (base_addr),
    .busy                (busy),
    .frame_done          (frame_done),
    .Sdr_init_done       (Sdr_init_done),
    .Sdr_busy            (Sdr_busy),
    .App_rd_en           (App_rd_en),
    .App_rd_addr         (App_rd_addr),
    .Sdr_rd_en           (Sdr_rd_en),
    .Sdr_rd_dout         (Sdr_rd_dout),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .udp_data_length     (udp_data_length),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_ack          (app_tx_ack)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]    byte_q [$];
  logic [AB-1:0] addr_q [$];
  int            pkt_q  [$];
  int words_delivered = 0;
  int cum_words = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;
  int req_mode = 0;
  bit early_ack = 1'b0;
  logic busy_s = 1'b0;
  logic init_s = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string got,
                          input string want);
    total++;
    bad++;
    $display("FAIL %s: got %s want %s", nm, got, want);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [AB-1:0] base);
    int left;
    int k;
    int pw;
    logic [AB-1:0] a;
    logic [31:0] word;
    left = FW;
    k = 0;
    while (left > 0) begin
      pw = (left < PW) ? left : PW;
      pkt_q.push_back(pw);
      for (int w = 0; w < pw; w++) begin
        a = base + AB'(k);
        word = 32'(a);
        if (w % RB == 0) addr_q.push_back(a);
        for (int b = 0; b < 4; b++) byte_q.push_back(word[8*b +: 8]);
        k++;
      end
      left -= pw;
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_App_rd_en"}, 32'(App_rd_en), 32'd0);
    chk({tag, "_App_rd_addr"}, 32'(App_rd_addr), 32'd0);
    chk({tag, "_tx_valid"}, 32'(app_tx_data_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(app_tx_data), 32'd0);
    chk({tag, "_udp_len"}, 32'(udp_data_length), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    byte_q.delete();
    addr_q.delete();
    pkt_q.delete();
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic run_frame(input logic [AB-1:0] base, input int mode,
                           input bit early, input bit second,
                           input bit init_gap);
    int fd0;
    int rc0;
    int n;
    req_mode = mode;
    early_ack = early;
    fd0 = fd_cnt;
    push_frame(base);
    if (init_gap) begin
      Sdr_init_done = 1'b0;
      Sdr_busy = 1'b1;
    end
    start = 1'b1;
    base_addr = base;
    tick(1);
    start = 1'b0;
    base_addr = '0;
    tick(2);
    chk("busy_after_start", 32'(busy), 32'd1);
    if (second) begin
      start = 1'b1;
      base_addr = 21'h155555;
      tick(1);
      start = 1'b0;
      base_addr = '0;
    end
    if (init_gap) begin
      rc0 = rd_cnt;
      tick(50);
      chk("no_rd_before_init", 32'(rd_cnt), 32'(rc0));
      Sdr_init_done = 1'b1;
      tick(20);
      chk("no_rd_while_sdr_busy", 32'(rd_cnt), 32'(rc0));
      Sdr_busy = 1'b0;
    end
    n = 0;
    while (fd_cnt == fd0 && n < TMO) begin
      tick(1);
      n++;
    end
    if (fd_cnt == fd0) begin
      fail_now("frame_done_timeout", "none", "pulse");
      do_reset();
    end else begin
      chk("busy_low_at_done", 32'(busy), 32'd0);
      chk("bytes_left", 32'(byte_q.size()), 32'd0);
      chk("bursts_left", 32'(addr_q.size()), 32'd0);
      chk("pkts_left", 32'(pkt_q.size()), 32'd0);
      tick(5);
      chk("single_done_pulse", 32'(fd_cnt), 32'(fd0 + 1));
    end
  endtask

  always @(posedge clk) begin
    busy_s <= Sdr_busy;
    init_s <= Sdr_init_done;
  end

  initial begin : done_mon
    forever begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_cnt++;
    end
  end

  initial begin : sdram_model
    logic [AB-1:0] pend [$];
    logic [AB-1:0] cur;
    int idx;
    int lat;
    bit act;
    bit gapped;
    Sdr_rd_en = 1'b0;
    Sdr_rd_dout = '0;
    act = 1'b0;
    idx = 0;
    lat = 0;
    gapped = 1'b0;
    cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        act = 1'b0;
        idx = 0;
        lat = 0;
        gapped = 1'b0;
        Sdr_rd_en = 1'b0;
        Sdr_rd_dout = '0;
        words_delivered = 0;
        continue;
      end
      if (App_rd_en) begin
        rd_cnt++;
        chk("rd_gate_busy_init", 32'({busy_s, init_s}), 32'd1);
        if (addr_q.size() == 0) fail_now("rd_addr", "extra burst", "none");
        else chk("rd_addr", 32'(App_rd_addr), 32'(addr_q.pop_front()));
        pend.push_back(App_rd_addr);
      end
      Sdr_rd_en = 1'b0;
      if (!act && pend.size() > 0) begin
        if (lat >= 3) begin
          act = 1'b1;
          cur = pend.pop_front();
          idx = 0;
          lat = 0;
        end else begin
          lat++;
        end
      end
      if (act) begin
        if (idx % 16 == 8 && !gapped) begin
          gapped = 1'b1;
        end else begin
          gapped = 1'b0;
          Sdr_rd_en = 1'b1;
          Sdr_rd_dout = 32'(cur + AB'(idx));
          idx++;
          words_delivered++;
          if (idx == RB) act = 1'b0;
        end
      end
    end
  end

  initial begin : udp_model
    int ph;
    int pw;
    int len;
    int issued;
    int rx;
    int wait_c;
    int gap;
    bit expv;
    bit tog;
    bit gap_done;
    bit early_done;
    bit r;
    app_tx_data_request = 1'b0;
    app_tx_ack = 1'b0;
    udp_tx_ready = 1'b1;
    ph = 0; pw = 0; len = 0; issued = 0; rx = 0; wait_c = 0;
    gap = 0; expv = 1'b0; tog = 1'b0; gap_done = 1'b0;
    early_done = 1'b1; r = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ph = 0;
        expv = 1'b0;
        issued = 0;
        rx = 0;
        app_tx_data_request = 1'b0;
        app_tx_ack = 1'b0;
        cum_words = 0;
        continue;
      end
      app_tx_ack = 1'b0;
      chk("valid_follows_req", 32'(app_tx_data_valid), 32'(expv));
      if (app_tx_data_valid === 1'b1) begin
        if (byte_q.size() == 0) fail_now("tx_byte", "extra byte", "none");
        else chk("tx_byte", 32'(app_tx_data), 32'(byte_q.pop_front()));
        rx++;
      end
      expv = 1'b0;
      case (ph)
        0: begin
          if (pkt_q.size() > 0 && words_delivered >= cum_words + pkt_q[0]) begin
            ph = 1;
            wait_c = 4;
          end
        end
        1: begin
          wait_c--;
          if (wait_c == 0) begin
            pw = pkt_q[0];
            len = pw * 4;
            chk("udp_data_length", 32'(udp_data_length), 32'(len));
            issued = 0;
            rx = 0;
            tog = 1'b1;
            gap = 0;
            gap_done = 1'b0;
            early_done = !(early_ack && len > 200);
            ph = 2;
          end
        end
        2: begin
          if (rx == len) begin
            app_tx_data_request = 1'b0;
            wait_c = 2;
            ph = 3;
          end else begin
            if (req_mode == 0) begin
              r = 1'b1;
            end else if (gap > 0) begin
              r = 1'b0;
              gap--;
            end else if (issued == 300 && !gap_done) begin
              r = 1'b0;
              gap = 9;
              gap_done = 1'b1;
            end else begin
              r = tog;
              tog = !tog;
            end
            app_tx_data_request = r;
            if (r && issued < len) begin
              issued++;
              expv = 1'b1;
            end
            // premature ack must not end the packet
            if (!early_done && rx >= 100) begin
              app_tx_ack = 1'b1;
              early_done = 1'b1;
            end
          end
        end
        3: begin
          wait_c--;
          if (wait_c == 0) begin
            app_tx_ack = 1'b1;
            cum_words += pw;
            void'(pkt_q.pop_front());
            ph = 0;
          end
        end
        default: ph = 0;
      endcase
    end
  end

  initial begin : main
    int n;
    start = 1'b0;
    base_addr = '0;
    Sdr_init_done = 1'b1;
    Sdr_busy = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check_reset_outs("reset");
    rst_n = 1'b1;
    tick(2);

    run_frame(21'h000100, 0, 1'b1, 1'b0, 1'b0);
    run_frame(21'h1FFFC0, 1, 1'b0, 1'b1, 1'b0);
    run_frame(21'h000040, 0, 1'b0, 1'b0, 1'b1);

    req_mode = 0;
    early_ack = 1'b0;
    push_frame(21'h000300);
    start = 1'b1;
    base_addr = 21'h000300;
    tick(1);
    start = 1'b0;
    base_addr = '0;
    n = 0;
    while (byte_q.size() > FW * 4 - 50 && n < TMO) begin
      tick(1);
      n++;
    end
    if (n >= TMO) fail_now("tx_start_timeout", "no bytes", "50 bytes");
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("async_rst");
    tick(3);
    byte_q.delete();
    addr_q.delete();
    pkt_q.delete();
    rst_n = 1'b1;
    tick(2);
    run_frame(21'h000300, 1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
